data_memory_hs: RTL and testbench

DATA_MEMORY_HS -- requirements
Module: data_memory_hs

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/data_memory_hs_if.sv | 42 ++++
 rtl/dmem_load_align.sv | 36 +++
 rtl/data_memory_hs.sv | 165 ++++++++++++++++
 tb/tb_data_memory_hs.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the handshaked data memory.
// Holds XLEN, load/store funct3 codes, FSM state type and legality check.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] S_B  = 3'd0;
   localparam logic [2:0] S_H  = 3'd1;
   localparam logic [2:0] S_W  = 3'd2;

   localparam logic [2:0] L_B  = 3'd0;
   localparam logic [2:0] L_H  = 3'd1;
   localparam logic [2:0] L_W  = 3'd2;
   localparam logic [2:0] L_BU = 3'd4;
   localparam logic [2:0] L_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // Misaligned halves/words and unused funct3 codes are rejected.
   function automatic logic dmem_illegal(
      input logic       we,
      input logic [2:0] f3,
      input logic [1:0] a
   );
      logic bad;
      bad = 1'b1;
      if (we) begin
         case (f3)
            S_B:     bad = 1'b0;
            S_H:     bad = a[0];
            S_W:     bad = (a != 2'b00);
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            L_B, L_BU: bad = 1'b0;
            L_H, L_HU: bad = a[0];
            L_W:       bad = (a != 2'b00);
            default:   bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// data_memory_hs_if: request/response handshake bundle of the data memory.
// slave = memory side (req_* in, rsp_* out), master = requester side.
interface data_memory_hs_if;

   logic                       req_valid_i;
   logic                       req_ready_o;
   logic                       req_we_i;
   logic [riscv_pkg::XLEN-1:0] req_addr_i;
   logic [riscv_pkg::XLEN-1:0] req_wdata_i;
   logic [2:0]                 req_funct3_i;
   logic                       rsp_valid_o;
   logic                       rsp_ready_i;
   logic [riscv_pkg::XLEN-1:0] rsp_rdata_o;
   logic                       rsp_err_o;

   modport slave (
      input  req_valid_i,
      output req_ready_o,
      input  req_we_i,
      input  req_addr_i,
      input  req_wdata_i,
      input  req_funct3_i,
      output rsp_valid_o,
      input  rsp_ready_i,
      output rsp_rdata_o,
      output rsp_err_o
   );

   modport master (
      output req_valid_i,
      input  req_ready_o,
      output req_we_i,
      output req_addr_i,
      output req_wdata_i,
      output req_funct3_i,
      input  rsp_valid_o,
      output rsp_ready_i,
      input  rsp_rdata_o,
      input  rsp_err_o
   );

endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed lane of a memory word and extends it.
// Ports: word_i (raw word), addr_i (byte offset), funct3_i (load type), data_o.
module dmem_load_align
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      addr_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      data_o = word_i;
      case (funct3_i)
         L_B:     data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         L_BU:    data_o = {{(XLEN-8){1'b0}}, byte_sel};
         L_H:     data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         L_HU:    data_o = {{(XLEN-16){1'b0}}, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/data_memory_hs.sv
// data_memory_hs: word-organised data RAM behind a valid/ready handshake.
// Ports: clk_i, rst_ni (sync, active-low), bus (slave side of the handshake).
module data_memory_hs
   import riscv_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   data_memory_hs_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];

   dmem_state_e     state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      f3_q, f3_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

   logic [AW-1:0]   idx;
   logic [XLEN-1:0] rd_word;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wr_data;
   logic [3:0]      wr_be;
   logic            mem_we;
   logic            unused_addr;

   // Only the word index and byte offset matter; the rest wraps.
   assign unused_addr = ^bus.req_addr_i[XLEN-1:AW+2];

   assign idx     = addr_q[AW+1:2];
   assign rd_word = mem[idx];

   dmem_load_align u_align (
      .word_i   (rd_word),
      .addr_i   (addr_q[1:0]),
      .funct3_i (f3_q),
      .data_o   (load_data)
   );

   // Replicate narrow store data so each lane sees its bytes.
   always_comb begin
      wr_be   = 4'b1111;
      wr_data = wdata_q;
      case (f3_q)
         S_B: begin
            wr_be   = 4'b0001 << addr_q[1:0];
            wr_data = {4{wdata_q[7:0]}};
         end
         S_H: begin
            wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata_q[15:0]}};
         end
         default: begin
            wr_be   = 4'b1111;
            wr_data = wdata_q;
         end
      endcase
   end

   assign mem_we = (state_q == BUSY) && (cnt_q == 4'd0) && we_q;

   // Gated by rst_ni so a reset on the access edge drops the store.
   always_ff @(posedge clk_i) begin
      if (rst_ni && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      f3_d        = f3_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid_i) begin
               we_d    = bus.req_we_i;
               addr_d  = bus.req_addr_i[AW+1:0];
               wdata_d = bus.req_wdata_i;
               f3_d    = bus.req_funct3_i;
               if (dmem_illegal(bus.req_we_i,
                                bus.req_funct3_i,
                                bus.req_addr_i[1:0])) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  state_d = BUSY;
                  cnt_d   = 4'(WAIT_STATES);
               end
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = we_q ? '0 : load_data;
            end
         end
         RESP: begin
            if (bus.rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         f3_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         f3_q        <= f3_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready_o = (state_q == IDLE);
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_rdata_o = rsp_rdata_q;
   assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: directed bench for data_memory_hs.
// dut0 runs with WAIT_STATES=0, dut1 with WAIT_STATES=3.
module tb_data_memory_hs;
   import riscv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   data_memory_hs_if if0 ();
   data_memory_hs_if if1 ();

   logic [1:0]  req_valid, req_we, rsp_ready;
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic [2:0]  req_f3 [2];
   logic [1:0]  req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata [2];

   assign if0.req_valid_i  = req_valid[0];
   assign if0.req_we_i     = req_we[0];
   assign if0.req_addr_i   = req_addr[0];
   assign if0.req_wdata_i  = req_wdata[0];
   assign if0.req_funct3_i = req_f3[0];
   assign if0.rsp_ready_i  = rsp_ready[0];
   assign req_ready[0]     = if0.req_ready_o;
   assign rsp_valid[0]     = if0.rsp_valid_o;
   assign rsp_err[0]       = if0.rsp_err_o;
   assign rsp_rdata[0]     = if0.rsp_rdata_o;

   assign if1.req_valid_i  = req_valid[1];
   assign if1.req_we_i     = req_we[1];
   assign if1.req_addr_i   = req_addr[1];
   assign if1.req_wdata_i  = req_wdata[1];
   assign if1.req_funct3_i = req_f3[1];
   assign if1.rsp_ready_i  = rsp_ready[1];
   assign req_ready[1]     = if1.req_ready_o;
   assign rsp_valid[1]     = if1.rsp_valid_o;
   assign rsp_err[1]       = if1.rsp_err_o;
   assign rsp_rdata[1]     = if1.rsp_rdata_o;

   data_memory_hs #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if0)
   );

   data_memory_hs #(.DEPTH(1024), .WAIT_STATES(3)) dut1 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if1)
   );

   int checks   = 0;
   int failures = 0;

   // Issues one request at posedge+1 and completes its handshake.
   // lat = edges after the acceptance edge until rsp_valid, -1 on timeout.
   task automatic do_req(
      input  int          s,
      input  logic        we,
      input  logic [31:0] a,
      input  logic [31:0] d,
      input  logic [2:0]  f,
      output logic [31:0] rd,
      output logic        er,
      output int          lat
   );
      req_valid[s] = 1'b1;
      req_we[s]    = we;
      req_addr[s]  = a;
      req_wdata[s] = d;
      req_f3[s]    = f;
      rsp_ready[s] = 1'b0;
      @(posedge clk); #1;
      req_valid[s] = 1'b0;
      lat = 0;
      while (!rsp_valid[s] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid[s]) lat = -1;
      rd = rsp_rdata[s];
      er = rsp_err[s];
      rsp_ready[s] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[s] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_we    = '0;
      rsp_ready = '0;
      for (int s = 0; s < 2; s++) begin
         req_addr[s]  = '0;
         req_wdata[s] = '0;
         req_f3[s]    = '0;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (req_ready[s] !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready[%0d] got=%b want=1", s, req_ready[s]);
         end
         checks++;
         if (rsp_valid[s] !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid[%0d] got=%b want=0", s, rsp_valid[s]);
         end
         checks++;
         if (rsp_rdata[s] !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata[%0d] got=%h want=0", s, rsp_rdata[s]);
         end
         checks++;
         if (rsp_err[s] !== 1'b0) begin
            failures++;
            $display("FAIL reset_err[%0d] got=%b want=0", s, rsp_err[s]);
         end
      end
   endtask

   task automatic test_word();
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, S_W, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, 32'h0}) begin
         failures++;
         $display("FAIL sw_rsp got=%b/%h want=0/0", er, rd);
      end
      checks++;
      if (lat !== 1) begin
         failures++;
         $display("FAIL sw_lat got=%0d want=1", lat);
      end
      do_req(0, 1'b0, 32'h10, 32'h0, L_W, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL lw_rsp got=%b/%h want=0/deadbeef", er, rd);
      end
      checks++;
      if (lat !== 1) begin
         failures++;
         $display("FAIL lw_lat got=%0d want=1", lat);
      end
   endtask

   task automatic test_subword();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        w [9];
      logic [31:0] a [9];
      logic [31:0] d [9];
      logic [2:0]  f [9];
      logic [31:0] exp [9];
      w = '{1, 1, 0, 0, 0, 0, 0, 1, 0};
      a = '{32'h10, 32'h13, 32'h13, 32'h13, 32'h10,
            32'h12, 32'h10, 32'h12, 32'h10};
      d = '{32'h11223344, 32'hABCDEF80, 0, 0, 0,
            0, 0, 32'h1234BEEF, 0};
      f = '{S_W, S_B, L_B, L_BU, L_W, L_H, L_HU, S_H, L_W};
      exp = '{32'h0, 32'h0, 32'hFFFFFF80, 32'h00000080,
              32'h80223344, 32'hFFFF8022, 32'h00003344,
              32'h0, 32'hBEEF3344};
      for (int i = 0; i < 9; i++) begin
         do_req(0, w[i], a[i], d[i], f[i], rd, er, lat);
         checks++;
         if ({er, rd} !== {1'b0, exp[i]} || lat !== 1) begin
            failures++;
            $display("FAIL subword[%0d] got=%b/%h lat=%0d want=0/%h lat=1",
                     i, er, rd, lat, exp[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        w [6];
      logic [31:0] a [6];
      logic [2:0]  f [6];
      w = '{0, 1, 0, 1, 0, 1};
      a = '{32'h11, 32'h12, 32'h10, 32'h10, 32'h13, 32'h13};
      f = '{L_H, S_W, 3'd3, 3'd5, L_HU, S_H};
      for (int i = 0; i < 6; i++) begin
         do_req(0, w[i], a[i], 32'hFFFFFFFF, f[i], rd, er, lat);
         checks++;
         if ({er, rd} !== {1'b1, 32'h0} || lat !== 0) begin
            failures++;
            $display("FAIL illegal[%0d] got=%b/%h lat=%0d want=1/0 lat=0",
                     i, er, rd, lat);
         end
      end
      do_req(0, 1'b0, 32'h10, 32'h0, L_W, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, 32'hBEEF3344}) begin
         failures++;
         $display("FAIL illegal_nowrite got=%b/%h want=0/beef3344", er, rd);
      end
   endtask

   task automatic test_back_to_back();
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'h10;
      req_f3[0]    = L_W;
      rsp_ready[0] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (req_ready[0] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_busy got=%b want=0", req_ready[0]);
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid[0], rsp_rdata[0]} !== {1'b1, 32'hBEEF3344}) begin
         failures++;
         $display("FAIL b2b_rsp1 got=%b/%h want=1/beef3344",
                  rsp_valid[0], rsp_rdata[0]);
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[0] = 1'b0;
      checks++;
      if ({req_ready[0], rsp_valid[0]} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_idle got=%b%b want=10",
                  req_ready[0], rsp_valid[0]);
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      checks++;
      if (req_ready[0] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_reaccept got=%b want=0", req_ready[0]);
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid[0], rsp_rdata[0]} !== {1'b1, 32'hBEEF3344}) begin
         failures++;
         $display("FAIL b2b_rsp2 got=%b/%h want=1/beef3344",
                  rsp_valid[0], rsp_rdata[0]);
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[0] = 1'b0;
   endtask

   task automatic test_wait();
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          n;
      do_req(1, 1'b1, 32'h40, 32'hCAFEF00D, S_W, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, 32'h0} || lat !== 4) begin
         failures++;
         $display("FAIL ws_store got=%b/%h lat=%0d want=0/0 lat=4",
                  er, rd, lat);
      end
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b0;
      req_addr[1]  = 32'h40;
      req_f3[1]    = L_W;
      rsp_ready[1] = 1'b0;
      @(posedge clk); #1;
      // A store presented while busy must be ignored.
      req_we[1]    = 1'b1;
      req_wdata[1] = 32'h0;
      req_f3[1]    = S_W;
      n = 0;
      while (!rsp_valid[1] && n < 40) begin
         checks++;
         if (req_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL ws_busy_ready n=%0d got=%b want=0",
                     n, req_ready[1]);
         end
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n !== 4 || rsp_valid[1] !== 1'b1) begin
         failures++;
         $display("FAIL ws_latency got=%0d want=4", n);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]}
             !== {1'b0, 1'b1, 1'b0, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL ws_hold[%0d] got=%b%b%b/%h want=010/cafef00d",
                     i, req_ready[1], rsp_valid[1], rsp_err[1],
                     rsp_rdata[1]);
         end
         @(posedge clk); #1;
      end
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[1] = 1'b0;
      checks++;
      if ({req_ready[1], rsp_valid[1]} !== 2'b10) begin
         failures++;
         $display("FAIL ws_release got=%b%b want=10",
                  req_ready[1], rsp_valid[1]);
      end
      do_req(1, 1'b0, 32'h40, 32'h0, L_W, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, 32'hCAFEF00D} || lat !== 4) begin
         failures++;
         $display("FAIL ws_ignored got=%b/%h lat=%0d want=0/cafef00d lat=4",
                  er, rd, lat);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(0, 1'b1, 32'h1000, 32'hA5A5A5A5, S_W, rd, er, lat);
      do_req(0, 1'b0, 32'h0000, 32'h0, L_W, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, 32'hA5A5A5A5}) begin
         failures++;
         $display("FAIL wrap got=%b/%h want=0/a5a5a5a5", er, rd);
      end
   endtask

   task automatic test_reset_busy();
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(1, 1'b1, 32'h20, 32'h11111111, S_W, rd, er, lat);
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'h20;
      req_wdata[1] = 32'h22222222;
      req_f3[1]    = S_W;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if ({req_ready[1], rsp_valid[1], rsp_err[1]} !== 3'b100) begin
         failures++;
         $display("FAIL rst_busy_state got=%b%b%b want=100",
                  req_ready[1], rsp_valid[1], rsp_err[1]);
      end
      repeat (5) @(posedge clk);
      #1;
      do_req(1, 1'b0, 32'h20, 32'h0, L_W, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, 32'h11111111} || lat !== 4) begin
         failures++;
         $display("FAIL rst_busy_cancel got=%b/%h lat=%0d want=0/11111111",
                  er, rd, lat);
      end
      do_req(0, 1'b0, 32'h0, 32'h0, L_W, rd, er, lat);
      checks++;
      if ({er, rd} !== {1'b0, 32'hA5A5A5A5}) begin
         failures++;
         $display("FAIL rst_persist got=%b/%h want=0/a5a5a5a5", er, rd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_word();
      test_subword();
      test_illegal();
      test_back_to_back();
      test_wait();
      test_wrap();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
